// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: drives the combinational ROM address, queues {pc, instr}
// in a small prefetch FIFO and hands entries to decode; handles redirect flush and halt.
module fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter int          ADDR_W   = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     halt,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic [31:0]              imem_data,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [31:0]              inst_data,
   output logic [31:0]              inst_pc,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     misalign_pulse
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   state_e            state_q;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              misalign_q, misalign_d;
   logic [31:0]       pc_mem_q   [DEPTH];
   logic [31:0]       data_mem_q [DEPTH];
   logic              push_s;
   logic              pop_s;
   logic              not_empty_s;

   assign not_empty_s    = (count_q != {CNT_W{1'b0}});
   assign inst_valid     = not_empty_s && !redirect_valid;
   assign pop_s          = inst_valid && inst_ready;
   assign imem_addr      = fetch_pc_q[ADDR_W+1:2];
   assign fifo_count     = count_q;
   assign misalign_pulse = misalign_q;
   assign inst_pc        = not_empty_s ? pc_mem_q[head_q]   : 32'h0000_0000;
   assign inst_data      = not_empty_s ? data_mem_q[head_q] : 32'h0000_0000;

   // A full FIFO may still accept a push when the head leaves in the same cycle.
   assign push_s = (state_q == ST_RUN) && !halt && !redirect_valid &&
                   ((count_q < CNT_W'(DEPTH)) || pop_s);

   // Next-state for PC, pointers, occupancy and the misalign flag.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      misalign_d = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         head_d     = {PTR_W{1'b0}};
         tail_d     = {PTR_W{1'b0}};
         count_d    = {CNT_W{1'b0}};
         misalign_d = |redirect_pc[1:0];
      end else begin
         if (push_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tail_d     = tail_q + PTR_W'(1);
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         if (pop_s) begin
            head_d = head_q + PTR_W'(1);
         end else begin
            head_d = head_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State, datapath registers and FIFO storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         head_q     <= {PTR_W{1'b0}};
         tail_q     <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         misalign_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= 32'h0000_0000;
            data_mem_q[i] <= 32'h0000_0000;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
         if (push_s) begin
            pc_mem_q[tail_q]   <= fetch_pc_q;
            data_mem_q[tail_q] <= imem_data;
         end
         // A redirect freezes the state so HALTED keeps waiting with the new PC.
         if (!redirect_valid) begin
            case (state_q)
               ST_IDLE:   state_q <= ST_RUN;
               ST_RUN:    state_q <= halt ? ST_HALTED : ST_RUN;
               ST_HALTED: state_q <= halt ? ST_HALTED : ST_RUN;
               default:   state_q <= ST_IDLE;
            endcase
         end else begin
            state_q <= state_q;
         end
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios then random traffic, all outputs
// compared each cycle against a queue-based reference model.
module tb_fetch_controller;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        halt = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [11:0] imem_addr;
   logic [31:0] imem_data;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [1:0]  fifo_count;
   logic        misalign_pulse;

   logic [31:0] rom [4096];
   logic [31:0] prog [5];

   int n_pass = 0;
   int n_total = 0;

   logic [63:0] m_q [$];
   logic [31:0] m_pc;
   logic        m_mis;
   logic        m_started;
   logic        m_halted;

   always #5 clk = ~clk;

   assign imem_data = rom[imem_addr];

   fetch_controller dut (
      .clk(clk), .rst_n(rst_n), .halt(halt),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc),
      .fifo_count(fifo_count), .misalign_pulse(misalign_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc      = 32'h0;
      m_mis     = 1'b0;
      m_started = 1'b0;
      m_halted  = 1'b0;
   endtask

   // One clock: drive at negedge, compare outputs, then advance the model at posedge.
   task automatic step(input logic h, input logic r, input logic [31:0] rp, input logic rdy);
      logic        pop;
      logic        push;
      logic [31:0] word;
      @(negedge clk);
      halt = h; redirect_valid = r; redirect_pc = rp; inst_ready = rdy;
      #1;
      chk("valid", {31'b0, inst_valid}, {31'b0, (m_q.size() != 0) && !r});
      chk("pc",    inst_pc,   (m_q.size() != 0) ? m_q[0][63:32] : 32'h0);
      chk("data",  inst_data, (m_q.size() != 0) ? m_q[0][31:0]  : 32'h0);
      chk("count", {30'b0, fifo_count}, 32'(m_q.size()));
      chk("addr",  {20'b0, imem_addr}, {20'b0, m_pc[13:2]});
      chk("mis",   {31'b0, misalign_pulse}, {31'b0, m_mis});
      @(posedge clk);
      pop = (m_q.size() != 0) && !r && rdy;
      if (r) begin
         m_q.delete();
         m_pc  = {rp[31:2], 2'b00};
         m_mis = |rp[1:0];
      end else begin
         push = m_started && !m_halted && !h && ((m_q.size() < DEPTH) || pop);
         word = rom[m_pc[13:2]];
         if (pop) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back({m_pc, word});
            m_pc = m_pc + 32'd4;
         end
         m_mis = 1'b0;
         if (!m_started) m_started = 1'b1;
         else m_halted = h;
      end
   endtask

   // Asynchronous reset mid-cycle; released just after a posedge so no edge goes unmodelled.
   task automatic do_reset();
      #3;
      rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
      #1;
      chk("rst_valid", {31'b0, inst_valid}, 32'h0);
      chk("rst_count", {30'b0, fifo_count}, 32'h0);
      chk("rst_pc",    inst_pc, 32'h0);
      chk("rst_addr",  {20'b0, imem_addr}, 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      prog[0] = 32'h00000293; prog[1] = 32'h00128293; prog[2] = 32'h00502023;
      prog[3] = 32'h00002303; prog[4] = 32'hFF5FF0EF;
      for (int i = 0; i < 4096; i++) rom[i] = $urandom();
      for (int i = 0; i < 5; i++) rom[i] = prog[i];
      model_reset();

      // 1: streaming with ready high
      do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      chk("t1_valid", {31'b0, inst_valid}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         chk("t1_pc", inst_pc, 32'(i * 4));
         chk("t1_data", inst_data, prog[i]);
         step(1'b0, 1'b0, 32'h0, 1'b1);
         #1;
      end

      // 2: backpressure from reset, then release
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("t2_count", {30'b0, fifo_count}, 32'd2);
      chk("t2_addr", {20'b0, imem_addr}, 32'd2);
      chk("t2_pc0", inst_pc, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      #1 chk("t2_pc4", inst_pc, 32'h4);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      #1 chk("t2_pc8", inst_pc, 32'h8);

      // 3: redirect to 0 while holding pc 8,C
      step(1'b1, 1'b1, 32'h0, 1'b1);
      #1 chk("t3_count", {30'b0, fifo_count}, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      #1 chk("t3_pc", inst_pc, 32'h0);

      // 4: halt, drain, resume
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
      #1 chk("t4_count", {30'b0, fifo_count}, 32'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

      // 5: misaligned redirect
      step(1'b0, 1'b1, 32'h0000_0006, 1'b1);
      #1 chk("t5_mis", {31'b0, misalign_pulse}, 32'h1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      chk("t5_mis_clr", {31'b0, misalign_pulse}, 32'h0);
      chk("t5_pc", inst_pc, 32'h4);

      // 6: ROM address wrap, then reset mid-stream
      step(1'b0, 1'b1, 32'h0000_3FFC, 1'b1);
      #1 chk("t6_addr_fff", {20'b0, imem_addr}, 32'hFFF);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      #1 chk("t6_addr_000", {20'b0, imem_addr}, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      #1 chk("t6_pc", inst_pc, 32'h4000);
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

      // Random traffic with one reset in the middle
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         step($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
              ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 64)),
              $urandom_range(0, 2) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
